vector_player: RTL and testbench



---
 rtl/vector_player_pkg.sv | 14 +
 rtl/vector_player_mem.sv | 33 +++
 rtl/vector_player.sv | 163 ++++++++++++++++
 tb/tb_vector_player.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_player_pkg.sv
// Shared types and helpers for the vector_player stimulus/response sequencer.
package vector_player_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int IN_W_DEF  = 20;
  localparam int OUT_W_DEF = 10;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/vector_player_mem.sv
// Slot storage: stimulus and expected-response arrays sharing one write port,
// each with its own asynchronous read address.
module vector_player_mem #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [IN_W-1:0]  wstim,
  input  logic [OUT_W-1:0] wexp,
  input  logic [AW-1:0]    stim_addr,
  output logic [IN_W-1:0]  stim_data,
  input  logic [AW-1:0]    exp_addr,
  output logic [OUT_W-1:0] exp_data
);

  logic [IN_W-1:0]  stim_mem [DEPTH];
  logic [OUT_W-1:0] exp_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      stim_mem[waddr] <= wstim;
      exp_mem[waddr]  <= wexp;
    end
  end

  assign stim_data = stim_mem[stim_addr];
  assign exp_data  = exp_mem[exp_addr];

endmodule

// File: rtl/vector_player.sv
// Stimulus/response sequencer: plays preloaded vectors into a DUT wrapper and scores responses.
// Optional result capture RAM enabled by defining VECTOR_PLAYER_CAPTURE_EN.
module vector_player
  import vector_player_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [IN_W-1:0]  load_stim,
  input  logic [OUT_W-1:0] load_exp,
  input  logic             start,
  input  logic [AW:0]      num_vec,
  output logic [IN_W-1:0]  stim_o,
  output logic             stim_valid,
  input  logic [OUT_W-1:0] resp_i,
  input  logic             resp_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      err_count,
  output logic [AW-1:0]    first_err_idx,
  output logic             timeout_flag,
  input  logic [AW-1:0]    rd_addr,
  output logic [OUT_W-1:0] rd_data
);

  localparam int          TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] ERR_MAX = 32'((64'd1 << (AW + 1)) - 64'd1);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [AW:0]      n_vec;
  logic [TW-1:0]    wcnt;
  logic [AW:0]      idx_nxt;
  logic [AW:0]      n_start;
  logic [AW:0]      err_inc;
  logic [IN_W-1:0]  stim_data;
  logic [OUT_W-1:0] exp_data;
  logic             mismatch;
  logic             idle_like;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign idx_nxt   = (AW + 1)'(idx) + (AW + 1)'(1);
  assign n_start   = (num_vec > (AW + 1)'(DEPTH)) ? (AW + 1)'(DEPTH) : num_vec;
  assign err_inc   = (AW + 1)'(sat_inc(32'(err_count), ERR_MAX));
  assign mismatch  = (resp_i != exp_data);

  // While waiting, prefetch the next stimulus so ISSUE can be entered with stim_o already valid.
  vector_player_mem #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .we        (load_we && idle_like),
    .waddr     (load_addr),
    .wstim     (load_stim),
    .wexp      (load_exp),
    .stim_addr ((state == WAIT) ? idx_nxt[AW-1:0] : '0),
    .stim_data (stim_data),
    .exp_addr  (idx),
    .exp_data  (exp_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stim_o        <= '0;
      stim_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      timeout_flag  <= 1'b0;
      idx           <= '0;
      n_vec         <= '0;
      wcnt          <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            timeout_flag  <= 1'b0;
            n_vec         <= n_start;
            wcnt          <= '0;
            if (n_start == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state      <= ISSUE;
              stim_o     <= stim_data;
              stim_valid <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              pass       <= 1'b0;
            end
          end
        end
        ISSUE: begin
          state      <= WAIT;
          stim_valid <= 1'b0;
          wcnt       <= '0;
        end
        WAIT: begin
          if (resp_valid) begin
            if (mismatch) begin
              err_count <= err_inc;
              if (err_count == '0) first_err_idx <= idx;
            end
            if (idx_nxt < n_vec) begin
              state      <= ISSUE;
              idx        <= idx_nxt[AW-1:0];
              stim_o     <= stim_data;
              stim_valid <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !mismatch && (err_count == '0);
            end
          end else if (wcnt == TW'(TIMEOUT - 1)) begin
            // Timeout counts as an error and abandons the remaining vectors.
            err_count    <= err_inc;
            if (err_count == '0) first_err_idx <= idx;
            timeout_flag <= 1'b1;
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= 1'b0;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VECTOR_PLAYER_CAPTURE_EN
  logic [OUT_W-1:0] cap_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && state == WAIT && resp_valid) cap_mem[idx] <= resp_i;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= cap_mem[rd_addr];
  end
`else
  logic unused_rd;
  assign unused_rd = ^rd_addr;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_vector_player.sv
// Bench for vector_player: behaves as a 1-cycle DUT wrapper, scoreboards issued stimuli.
module tb_vector_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [19:0] load_stim;
  logic [9:0]  load_exp;
  logic        start;
  logic [4:0]  num_vec;
  logic [19:0] stim_o;
  logic        stim_valid;
  logic [9:0]  resp_i;
  logic        resp_valid;
  logic        busy, done, pass, timeout_flag;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic [3:0]  rd_addr;
  logic [9:0]  rd_data;

  logic        dut_en;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          cyc = 0;
  int          last_cyc = -1;
  logic [19:0] stim_tab [16];
  logic [19:0] exp_q [$];

  typedef struct {
    int          nv;
    logic [15:0] mask;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
    int          exp_pulses;
  } vec_t;
  vec_t tbl [6];

  vector_player #(.IN_W(20), .OUT_W(10), .DEPTH(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
    .load_stim(load_stim), .load_exp(load_exp), .start(start), .num_vec(num_vec),
    .stim_o(stim_o), .stim_valid(stim_valid), .resp_i(resp_i), .resp_valid(resp_valid),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .timeout_flag(timeout_flag),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dut_fn(input logic [19:0] s);
    return s[9:0] ^ s[19:10];
  endfunction

  // Combinational DUT behind a 1-cycle register stage.
  always @(posedge clk) begin
    resp_valid <= stim_valid & dut_en;
    resp_i     <= dut_fn(stim_o);
    cyc        <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && stim_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stim_unexpected actual=%0h required=none", stim_o);
      end else begin
        chk("stim_o", 32'(stim_o), 32'(exp_q.pop_front()));
      end
      if (last_cyc >= 0) chk("issue_spacing", cyc - last_cyc, 2);
      last_cyc = cyc;
    end
  end

  task automatic load_all(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_we   = 1'b1;
      load_addr = 4'(i);
      load_stim = stim_tab[i];
      load_exp  = dut_fn(stim_tab[i]) ^ {9'b0, mask[i]};
    end
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic start_run(input int nv, input int npush);
    for (int i = 0; i < npush; i++) exp_q.push_back(stim_tab[i]);
    pulses   = 0;
    last_cyc = -1;
    @(negedge clk);
    start   = 1'b1;
    num_vec = 5'(nv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int waited);
    waited = 0;
    while (!done && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("done_reached", 32'(done), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stim_o"}, 32'(stim_o), 0);
    chk({tag, "_stim_valid"}, 32'(stim_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_first_err"}, 32'(first_err_idx), 0);
    chk({tag, "_timeout"}, 32'(timeout_flag), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int k;
    for (int i = 0; i < 16; i++) stim_tab[i] = 20'(i * 32'h0A5C3 + 32'h123);
    stim_tab[0] = 20'h00001;
    stim_tab[1] = 20'h00010;
    stim_tab[2] = 20'h10000;
    // nv, corrupt mask, err, first, pass, pulses
    tbl[0] = '{3,  16'h0000, 0, 0,  1'b1, 3};
    tbl[1] = '{3,  16'h0002, 1, 1,  1'b0, 3};
    tbl[2] = '{0,  16'h0000, 0, 0,  1'b1, 0};
    tbl[3] = '{31, 16'h8000, 1, 15, 1'b0, 16};
    tbl[4] = '{16, 16'h0210, 2, 4,  1'b0, 16};
    tbl[5] = '{5,  16'hFFFF, 5, 0,  1'b0, 5};

    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_stim = '0; load_exp = '0;
    start = 1'b0; num_vec = '0; rd_addr = '0; dut_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    foreach (tbl[r]) begin
      load_all(tbl[r].mask);
      start_run(tbl[r].nv, (tbl[r].nv > 16) ? 16 : tbl[r].nv);
      wait_done(waited);
      if (tbl[r].nv == 0) chk("zero_done_latency", waited, 0);
      chk($sformatf("row%0d_err", r), 32'(err_count), tbl[r].exp_err);
      chk($sformatf("row%0d_first", r), 32'(first_err_idx), tbl[r].exp_first);
      chk($sformatf("row%0d_pass", r), 32'(pass), 32'(tbl[r].exp_pass));
      chk($sformatf("row%0d_busy", r), 32'(busy), 0);
      chk($sformatf("row%0d_timeout", r), 32'(timeout_flag), 0);
      chk($sformatf("row%0d_pulses", r), pulses, tbl[r].exp_pulses);
      chk($sformatf("row%0d_queue", r), exp_q.size(), 0);
    end

    // No response ever: single issue, then abort 8 cycles into WAIT.
    load_all(16'h0000);
    dut_en = 1'b0;
    start_run(2, 1);
    chk("to_first_pulse", 32'(stim_valid), 1);
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("to_latency", k, 9);
    chk("to_err", 32'(err_count), 1);
    chk("to_flag", 32'(timeout_flag), 1);
    chk("to_first", 32'(first_err_idx), 0);
    chk("to_pass", 32'(pass), 0);
    chk("to_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("to_pulses", pulses, 1);
    dut_en = 1'b1;

    // Reset while waiting on the third vector.
    start_run(3, 3);
    k = 0;
    while (!(stim_valid && stim_o == stim_tab[2]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_third_issued", 32'(stim_o), 32'(stim_tab[2]));
    dut_en = 1'b0;
    @(negedge clk);
    chk("rstmid_in_wait", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rstmid");
    rst = 1'b0;
    dut_en = 1'b1;
    chk("rstmid_queue", exp_q.size(), 0);
    exp_q.delete();
    start_run(3, 3);
    wait_done(waited);
    chk("rerun_pass", 32'(pass), 1);
    chk("rerun_err", 32'(err_count), 0);
    chk("rerun_pulses", pulses, 3);

    // start and load_we while busy must be ignored.
    start_run(3, 3);
    start     = 1'b1;
    num_vec   = 5'd0;
    load_we   = 1'b1;
    load_addr = 4'd1;
    load_stim = 20'hABCDE;
    load_exp  = dut_fn(stim_tab[1]) ^ 10'h001;
    @(negedge clk);
    start   = 1'b0;
    load_we = 1'b0;
    wait_done(waited);
    chk("busy_ign_pass", 32'(pass), 1);
    chk("busy_ign_pulses", pulses, 3);
    start_run(3, 3);
    wait_done(waited);
    chk("load_ign_pass", 32'(pass), 1);
    chk("load_ign_err", 32'(err_count), 0);

    @(negedge clk);
    rd_addr = 4'd2;
    @(negedge clk);
`ifdef VECTOR_PLAYER_CAPTURE_EN
    chk("rd_data_slot2", 32'(rd_data), 32'(dut_fn(stim_tab[2])));
    rd_addr = 4'd0;
    @(negedge clk);
    chk("rd_data_slot0", 32'(rd_data), 32'(dut_fn(stim_tab[0])));
`else
    chk("rd_data_zero", 32'(rd_data), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
